tx_pattern_sequencer: RTL and testbench
=======================================

Name: tx_pattern_sequencer

Overview:
- Schedules the radio TX sample slot between the user TX stream and an internal test-pattern source, on radio_clk.
- Runs programmable bursts: N pattern samples, then a zero-filled gap, repeated R extra times, then returns to passthrough.
- Sits between the DSP TX chain output and the radio frontend.
- Replaces free-running pattern generators with a start/abort/done controlled sequence.

Parameters:
CNT_W, 16, width of the burst-length, gap and repeat counters
HP_W, 8, width of the square-wave half-period counter

Ports:
radio_clk  input  1  clock
radio_rst  input  1  reset, synchronous, active-high
strobe  input  1  sample strobe; all sample-level activity advances only when high
cfg_start  input  1  1-cycle pulse; starts a burst sequence (honoured in IDLE only)
cfg_abort  input  1  1-cycle pulse; terminates any sequence
cfg_mode  input  2  0 square, 1 constant, 2 zero, 3 ramp
cfg_amplitude  input  16  pattern amplitude, I and Q
cfg_half_period  input  HP_W  strobes per square half-period (0 treated as 1)
cfg_num_samples  input  CNT_W  pattern samples per burst
cfg_gap  input  CNT_W  zero samples after each burst
cfg_repeats  input  CNT_W  additional bursts after the first
tx_in  input  32  user sample {I[31:16],Q[15:0]}
tx_out  output  32  sample to radio
busy  output  1  high in RUN, GAP, DONE
done  output  1  1-cycle pulse at sequence completion
pattern_active  output  1  high while tx_out carries a RUN sample

Behaviour:
- Reset values:
  - tx_out=0, busy=0, done=0, pattern_active=0.
  - State IDLE; all counters 0.
  - Reset mid-sequence aborts with no done pulse.
- States:
  - IDLE: on strobe, tx_out<=tx_in (1-cycle registered passthrough).
  - RUN: on strobe, tx_out<=pattern sample; pattern_active=1.
  - GAP: on strobe, tx_out<=0.
  - DONE: lasts one cycle; done=1; tx_out holds its value; next state IDLE.
- Between strobes, tx_out holds its value in all states.
- Start:
  - cfg_start in IDLE latches all cfg_* into shadow registers. Later cfg changes do not affect the running sequence.
  - If latched num_samples==0: go to DONE directly. No pattern is emitted.
  - Otherwise go to RUN. The first pattern sample appears at the first strobe after the start cycle.
  - cfg_start outside IDLE is ignored.
- RUN:
  - Sample counter s counts strobes 0..num_samples-1.
  - On the strobe where s==num_samples-1:
    - If gap!=0, go to GAP.
    - Else if repeats_left!=0, decrement repeats_left and restart RUN with s=0.
    - Else go to DONE.
- GAP:
  - Counts gap strobes.
  - On the last one: if repeats_left!=0, decrement it and go to RUN; else go to DONE.
- Square pattern (mode 0):
  - Phase bit starts at 1 on each burst.
  - Toggles after every half_period strobes. The half-period counter resets at burst start.
  - Phase 1 gives {amp,amp}; phase 0 gives 32'h0.
- Constant pattern (mode 1): {amp,amp} on every sample.
- Zero pattern (mode 2): 0 on every sample.
- Abort:
  - Has priority over start and over all transitions.
  - Next state IDLE; no done pulse; busy=0 the following cycle.
  - tx_out holds until the next strobe, then passes tx_in through.
- Simultaneous start+abort in IDLE: abort wins; stay IDLE.
- Final strobe coinciding with abort: abort wins; no done pulse.
- Counters never wrap: the comparisons are exact against the latched values.

Optional Feature:
Macro: PATTERN_RAMP_EN
- Defined: mode 3 emits I=Q=ramp value.
  - Ramp starts at 0 on each burst and increments by 1 per RUN strobe.
  - Wraps from 16'hFFFF to 16'h0000.
- Undefined: mode 3 behaves exactly as mode 2 (zero). No ramp register is synthesised.

Decomposition:
- Shared package tx_pattern_pkg holds:
  - Mode encodings MODE_SQUARE, MODE_CONST, MODE_ZERO, MODE_RAMP.
  - State encoding typedef (IDLE, RUN, GAP, DONE).
  - Default widths.
- One natural sub-module: tx_pattern_gen.
  - Inputs: mode, amplitude, half_period, strobe, burst-restart.
  - Output: the current pattern sample.
  - Owns the phase bit, half-period counter and ramp counter.
- The top level keeps the FSM, sequence counters and output mux.

Test Plan:
1. Passthrough: IDLE, strobe every cycle, tx_in=32'h12345678 -> tx_out=32'h12345678 one cycle later; busy=0.
2. Square burst: mode 0, amp 16'hAAAA, half_period 2, num_samples 8, gap 0, repeats 0, strobe every cycle.
   - tx_out sequence AAAAAAAA x2, 0 x2, AAAAAAAA x2, 0 x2.
   - done pulses once, one cycle after the 8th sample; then passthrough resumes.
3. Repeat+gap: mode 1, amp 16'h0100, num 3, gap 2, repeats 1, strobe every 2nd cycle.
   - Samples: 01000100 x3, 0 x2, 01000100 x3, 0 x2.
   - Then done; busy high throughout.
4. Abort: during RUN of a num 100 burst, pulse cfg_abort at sample 10.
   - busy=0 the next cycle; no done pulse.
   - The next strobe gives tx_out=tx_in.
5. Edge cases:
   - num_samples=0 start: done one cycle after start, no pattern sample.
   - cfg_start while busy: ignored.
   - start+abort in the same cycle: stays IDLE.
6. Ramp, only with PATTERN_RAMP_EN defined: mode 3, num 4 -> tx_out 00000000, 00010001, 00020002, 00030003.
   - Without the macro, the same stimulus gives all-zero samples.

Source files
------------

// File: rtl/tx_pattern_pkg.sv
// Shared types for the TX pattern sequencer: mode and state encodings,
// default widths and an I/Q packing helper.
package tx_pattern_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int HP_W_DEF  = 8;
    localparam int AMP_W     = 16;
    localparam int SAMPLE_W  = 32;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_CONST  = 2'd1,
        MODE_ZERO   = 2'd2,
        MODE_RAMP   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [SAMPLE_W-1:0] iq_pack(
        input logic [AMP_W-1:0] i_val,
        input logic [AMP_W-1:0] q_val
    );
        return {i_val, q_val};
    endfunction

endpackage

// File: rtl/tx_pattern_gen.sv
// Test-pattern source: square / constant / zero, plus ramp when
// PATTERN_RAMP_EN is defined (otherwise ramp mode yields zero).
module tx_pattern_gen
    import tx_pattern_pkg::*;
#(
    parameter int HP_W = HP_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                strobe,
    input  logic                restart,
    input  mode_e               mode,
    input  logic [AMP_W-1:0]    amplitude,
    input  logic [HP_W-1:0]     half_period,
    output logic [SAMPLE_W-1:0] sample
);

    logic            phase_q, phase_d;
    logic [HP_W-1:0] hp_cnt_q, hp_cnt_d;
    logic [HP_W-1:0] hp_eff;

`ifdef PATTERN_RAMP_EN
    logic [AMP_W-1:0] ramp_q, ramp_d;
`endif

    assign hp_eff = (half_period == '0) ? HP_W'(1) : half_period;

    // restart wins over strobe so the next burst always starts in phase 1
    always_comb begin
        phase_d  = phase_q;
        hp_cnt_d = hp_cnt_q;
        if (restart) begin
            phase_d  = 1'b1;
            hp_cnt_d = '0;
        end else if (strobe) begin
            if (hp_cnt_q == hp_eff - HP_W'(1)) begin
                phase_d  = ~phase_q;
                hp_cnt_d = '0;
            end else begin
                hp_cnt_d = hp_cnt_q + HP_W'(1);
            end
        end
    end

`ifdef PATTERN_RAMP_EN
    always_comb begin
        ramp_d = ramp_q;
        if (restart) begin
            ramp_d = '0;
        end else if (strobe) begin
            ramp_d = ramp_q + AMP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= 1'b1;
            hp_cnt_q <= '0;
        end else begin
            phase_q  <= phase_d;
            hp_cnt_q <= hp_cnt_d;
        end
    end

    always_comb begin
        sample = '0;
        unique case (mode)
            MODE_SQUARE: sample = phase_q ? iq_pack(amplitude, amplitude) : '0;
            MODE_CONST:  sample = iq_pack(amplitude, amplitude);
            MODE_ZERO:   sample = '0;
`ifdef PATTERN_RAMP_EN
            MODE_RAMP:   sample = iq_pack(ramp_q, ramp_q);
`else
            MODE_RAMP:   sample = '0;
`endif
        endcase
    end

endmodule

// File: rtl/tx_pattern_sequencer.sv
// Burst sequencer muxing user TX samples with an internal test pattern.
// Ramp mode is available only when PATTERN_RAMP_EN is defined.
module tx_pattern_sequencer
    import tx_pattern_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int HP_W  = HP_W_DEF
) (
    input  logic                radio_clk,
    input  logic                radio_rst,
    input  logic                strobe,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [1:0]          cfg_mode,
    input  logic [AMP_W-1:0]    cfg_amplitude,
    input  logic [HP_W-1:0]     cfg_half_period,
    input  logic [CNT_W-1:0]    cfg_num_samples,
    input  logic [CNT_W-1:0]    cfg_gap,
    input  logic [CNT_W-1:0]    cfg_repeats,
    input  logic [SAMPLE_W-1:0] tx_in,
    output logic [SAMPLE_W-1:0] tx_out,
    output logic                busy,
    output logic                done,
    output logic                pattern_active
);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [AMP_W-1:0]    amp_q, amp_d;
    logic [HP_W-1:0]     hp_q, hp_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    gap_q, gap_d;
    logic [CNT_W-1:0]    reps_q, reps_d;
    logic [CNT_W-1:0]    s_q, s_d;
    logic [CNT_W-1:0]    g_q, g_d;
    logic [SAMPLE_W-1:0] tx_out_q, tx_out_d;
    logic                pat_q, pat_d;
    logic                burst_restart;
    logic                gen_restart;
    logic                gen_step;
    logic [SAMPLE_W-1:0] pattern;

    always_ff @(posedge radio_clk) begin
        if (radio_rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_SQUARE;
            amp_q    <= '0;
            hp_q     <= '0;
            num_q    <= '0;
            gap_q    <= '0;
            reps_q   <= '0;
            s_q      <= '0;
            g_q      <= '0;
            tx_out_q <= '0;
            pat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            amp_q    <= amp_d;
            hp_q     <= hp_d;
            num_q    <= num_d;
            gap_q    <= gap_d;
            reps_q   <= reps_d;
            s_q      <= s_d;
            g_q      <= g_d;
            tx_out_q <= tx_out_d;
            pat_q    <= pat_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        amp_d         = amp_q;
        hp_d          = hp_q;
        num_d         = num_q;
        gap_d         = gap_q;
        reps_d        = reps_q;
        s_d           = s_q;
        g_d           = g_q;
        burst_restart = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    mode_d  = mode_e'(cfg_mode);
                    amp_d   = cfg_amplitude;
                    hp_d    = cfg_half_period;
                    num_d   = cfg_num_samples;
                    gap_d   = cfg_gap;
                    reps_d  = cfg_repeats;
                    s_d     = '0;
                    g_d     = '0;
                    state_d = (cfg_num_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (strobe) begin
                    if (s_q == num_q - CNT_W'(1)) begin
                        s_d = '0;
                        if (gap_q != '0) begin
                            g_d     = '0;
                            state_d = ST_GAP;
                        end else if (reps_q != '0) begin
                            reps_d        = reps_q - CNT_W'(1);
                            burst_restart = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        s_d = s_q + CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (strobe) begin
                    if (g_q == gap_q - CNT_W'(1)) begin
                        g_d = '0;
                        if (reps_q != '0) begin
                            reps_d  = reps_q - CNT_W'(1);
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        g_d = g_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
        // abort overrides every transition above, including a start in IDLE
        if (cfg_abort) begin
            state_d       = ST_IDLE;
            s_d           = '0;
            g_d           = '0;
            burst_restart = 1'b0;
            mode_d        = mode_q;
            amp_d         = amp_q;
            hp_d          = hp_q;
            num_d         = num_q;
            gap_d         = gap_q;
            reps_d        = reps_q;
        end
    end

    always_comb begin
        tx_out_d = tx_out_q;
        pat_d    = pat_q;
        if (strobe && !cfg_abort) begin
            unique case (state_q)
                ST_IDLE: begin
                    tx_out_d = tx_in;
                    pat_d    = 1'b0;
                end
                ST_RUN: begin
                    tx_out_d = pattern;
                    pat_d    = 1'b1;
                end
                ST_GAP: begin
                    tx_out_d = '0;
                    pat_d    = 1'b0;
                end
                ST_DONE: begin
                    tx_out_d = tx_out_q;
                    pat_d    = pat_q;
                end
            endcase
        end
    end

    // generator sits at its burst-start point whenever no burst is running
    assign gen_restart = (state_q != ST_RUN) || burst_restart;
    assign gen_step    = strobe && (state_q == ST_RUN);

    tx_pattern_gen #(
        .HP_W (HP_W)
    ) u_gen (
        .clk         (radio_clk),
        .rst         (radio_rst),
        .strobe      (gen_step),
        .restart     (gen_restart),
        .mode        (mode_q),
        .amplitude   (amp_q),
        .half_period (hp_q),
        .sample      (pattern)
    );

    assign tx_out         = tx_out_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign pattern_active = pat_q;

endmodule

// File: tb/tb_tx_pattern_sequencer.sv
// Randomized and directed bench for tx_pattern_sequencer against a
// sequence-list reference model.
module tb_tx_pattern_sequencer;

    logic        radio_clk = 1'b0;
    logic        radio_rst = 1'b1;
    logic        strobe = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_amplitude = '0;
    logic [7:0]  cfg_half_period = '0;
    logic [15:0] cfg_num_samples = '0;
    logic [15:0] cfg_gap = '0;
    logic [15:0] cfg_repeats = '0;
    logic [31:0] tx_in = '0;
    logic [31:0] tx_out;
    logic        busy;
    logic        done;
    logic        pattern_active;

    int errors = 0;
    int checks = 0;

    always #5 radio_clk = ~radio_clk;

    tx_pattern_sequencer dut (
        .radio_clk       (radio_clk),
        .radio_rst       (radio_rst),
        .strobe          (strobe),
        .cfg_start       (cfg_start),
        .cfg_abort       (cfg_abort),
        .cfg_mode        (cfg_mode),
        .cfg_amplitude   (cfg_amplitude),
        .cfg_half_period (cfg_half_period),
        .cfg_num_samples (cfg_num_samples),
        .cfg_gap         (cfg_gap),
        .cfg_repeats     (cfg_repeats),
        .tx_in           (tx_in),
        .tx_out          (tx_out),
        .busy            (busy),
        .done            (done),
        .pattern_active  (pattern_active)
    );

    // model: 0 idle, 1 sequence in progress, 2 done cycle
    int          m_state = 0;
    logic [31:0] m_tx = '0;
    bit          m_pat = 1'b0;
    logic [31:0] seq_val[$];
    bit          seq_run[$];
    int          seq_idx = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // expected sample stream, straight from the burst/gap/repeat rules
    task automatic build_seq();
        int hpe;
        logic [31:0] v;
        logic [15:0] k16;
        seq_val.delete();
        seq_run.delete();
        seq_idx = 0;
        hpe = (cfg_half_period == 0) ? 1 : int'(cfg_half_period);
        for (int b = 0; b <= int'(cfg_repeats); b++) begin
            for (int k = 0; k < int'(cfg_num_samples); k++) begin
                k16 = 16'(k);
                case (cfg_mode)
                    2'd0: v = (((k / hpe) % 2) == 0) ?
                              {cfg_amplitude, cfg_amplitude} : 32'h0;
                    2'd1: v = {cfg_amplitude, cfg_amplitude};
`ifdef PATTERN_RAMP_EN
                    2'd3: v = {k16, k16};
`endif
                    default: v = 32'h0;
                endcase
                seq_val.push_back(v);
                seq_run.push_back(1'b1);
            end
            for (int g = 0; g < int'(cfg_gap); g++) begin
                seq_val.push_back(32'h0);
                seq_run.push_back(1'b0);
            end
        end
    endtask

    task automatic model_step(input bit rst, input bit stb, input bit st,
                              input bit ab, input logic [31:0] tin);
        if (rst) begin
            m_state = 0;
            m_tx    = '0;
            m_pat   = 1'b0;
        end else if (ab) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: begin
                    if (stb) begin
                        m_tx  = tin;
                        m_pat = 1'b0;
                    end
                    if (st) begin
                        build_seq();
                        m_state = (cfg_num_samples == 0) ? 2 : 1;
                    end
                end
                1: begin
                    if (stb) begin
                        m_tx  = seq_val[seq_idx];
                        m_pat = seq_run[seq_idx];
                        seq_idx++;
                        if (seq_idx == seq_val.size()) m_state = 2;
                    end
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic tick(input bit stb, input bit st, input bit ab,
                        input logic [31:0] tin);
        @(negedge radio_clk);
        strobe    = stb;
        cfg_start = st;
        cfg_abort = ab;
        tx_in     = tin;
        @(posedge radio_clk);
        model_step(radio_rst, stb, st, ab, tin);
        #1;
        check("tx_out", tx_out, m_tx);
        check("busy", 32'(busy), 32'(m_state != 0));
        check("done", 32'(done), 32'(m_state == 2));
        check("pattern_active", 32'(pattern_active), 32'(m_pat));
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic [15:0] amp,
                           input logic [7:0] hp, input logic [15:0] num,
                           input logic [15:0] gap, input logic [15:0] reps);
        cfg_mode        = mode;
        cfg_amplitude   = amp;
        cfg_half_period = hp;
        cfg_num_samples = num;
        cfg_gap         = gap;
        cfg_repeats     = reps;
    endtask

    initial begin
        radio_rst = 1'b1;
        repeat (3) tick(1'b1, 1'b0, 1'b0, $urandom);
        check("reset_tx_out", tx_out, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        radio_rst = 1'b0;

        // passthrough
        repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h12345678);
        check("pass_value", tx_out, 32'h12345678);

        // square burst
        set_cfg(2'd0, 16'hAAAA, 8'd2, 16'd8, 16'd0, 16'd0);
        tick(1'b1, 1'b1, 1'b0, $urandom);
        set_cfg(2'd1, 16'h5555, 8'd7, 16'd2, 16'd3, 16'd4);
        repeat (12) tick(1'b1, 1'b0, 1'b0, $urandom);

        // repeat with gap, strobe every second cycle
        set_cfg(2'd1, 16'h0100, 8'd0, 16'd3, 16'd2, 16'd1);
        tick(1'b0, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 26; i++) tick(i[0], 1'b0, 1'b0, $urandom);

        // abort mid-burst
        set_cfg(2'd1, 16'h7777, 8'd1, 16'd100, 16'd0, 16'd0);
        tick(1'b0, 1'b1, 1'b0, $urandom);
        repeat (10) tick(1'b1, 1'b0, 1'b0, $urandom);
        tick(1'b1, 1'b0, 1'b1, $urandom);
        tick(1'b0, 1'b0, 1'b0, $urandom);
        tick(1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
        check("abort_pass", tx_out, 32'hCAFEF00D);

        // zero-length start
        set_cfg(2'd1, 16'h1111, 8'd1, 16'd0, 16'd2, 16'd2);
        tick(1'b1, 1'b1, 1'b0, $urandom);
        repeat (3) tick(1'b1, 1'b0, 1'b0, $urandom);

        // start while busy is ignored
        set_cfg(2'd1, 16'h2222, 8'd1, 16'd5, 16'd0, 16'd0);
        tick(1'b1, 1'b1, 1'b0, $urandom);
        set_cfg(2'd0, 16'h3333, 8'd1, 16'd9, 16'd1, 16'd1);
        tick(1'b1, 1'b1, 1'b0, $urandom);
        repeat (8) tick(1'b1, 1'b0, 1'b0, $urandom);

        // start and abort together
        tick(1'b1, 1'b1, 1'b1, $urandom);
        repeat (2) tick(1'b1, 1'b0, 1'b0, $urandom);

        // ramp mode
        set_cfg(2'd3, 16'h4444, 8'd1, 16'd4, 16'd0, 16'd0);
        tick(1'b0, 1'b1, 1'b0, $urandom);
        repeat (6) tick(1'b1, 1'b0, 1'b0, $urandom);

        // reset mid-sequence
        set_cfg(2'd1, 16'h5A5A, 8'd1, 16'd20, 16'd0, 16'd0);
        tick(1'b1, 1'b1, 1'b0, $urandom);
        repeat (4) tick(1'b1, 1'b0, 1'b0, $urandom);
        radio_rst = 1'b1;
        tick(1'b1, 1'b0, 1'b0, $urandom);
        radio_rst = 1'b0;
        repeat (3) tick(1'b1, 1'b0, 1'b0, $urandom);

        // random traffic with cfg changing every cycle
        for (int i = 0; i < 3000; i++) begin
            set_cfg(2'($urandom_range(0, 3)), 16'($urandom),
                    8'($urandom_range(0, 3)),
                    16'(($urandom_range(0, 9) == 0) ?
                        $urandom_range(0, 20) : $urandom_range(0, 5)),
                    16'($urandom_range(0, 3)), 16'($urandom_range(0, 2)));
            radio_rst = ($urandom_range(0, 499) == 0);
            tick(($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 59) == 0), $urandom);
        end
        radio_rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
